// File: rtl/systolic_gemm_engine.sv
`default_nettype none
// ============================================================================
// Module   : systolic_gemm_engine
// Brief    : Output-stationary ROWSxCOLS systolic GEMM tile with skewed
//            operand feed, saturating accumulators and row-serial drain.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_gemm_engine #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 24,
  parameter int K_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [K_WIDTH-1:0]            i_k_len,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    i_a_vec,
  input  logic [COLS*WEIGHT_WIDTH-1:0]  i_w_vec,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [COLS*ACCUM_WIDTH-1:0]   o_out_data,
  output logic [$clog2(ROWS)-1:0]       o_out_row,
  output logic                          o_out_last,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_overflow
);
  localparam int c_ROW_W   = $clog2(ROWS);
  localparam int c_FLUSH_W = $clog2(ROWS + COLS + 1);
  localparam int c_PROD_W  = DATA_WIDTH + WEIGHT_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [K_WIDTH-1:0]   c_K_ONE      = K_WIDTH'(1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(ROWS + COLS - 1);
  localparam logic [c_ROW_W-1:0]   c_ROW_ONE    = c_ROW_W'(1);
  localparam logic [c_ROW_W-1:0]   c_LAST_ROW   = c_ROW_W'(ROWS - 1);
  localparam logic [ACCUM_WIDTH-1:0] c_ACC_MAX  = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic [ACCUM_WIDTH-1:0] c_ACC_MIN  = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

  logic [1:0]           r_state;
  logic [K_WIDTH-1:0]   r_k_len;
  logic [K_WIDTH-1:0]   r_beat_cnt;
  logic [c_FLUSH_W-1:0] r_flush_cnt;
  logic [c_ROW_W-1:0]   r_out_row;
  logic                 r_done;
  logic                 r_overflow;

  logic w_accept;
  logic w_clear;
  logic w_last_beat;

  logic [DATA_WIDTH-1:0]   w_a_in  [ROWS][COLS];
  logic                    w_a_vld [ROWS][COLS];
  logic [WEIGHT_WIDTH-1:0] w_w_in  [ROWS][COLS];
  logic                    w_w_vld [ROWS][COLS];
  logic [ACCUM_WIDTH-1:0]  w_acc   [ROWS][COLS];
  logic [ROWS*COLS-1:0]    w_sat;

  assign w_accept    = (r_state == S_LOAD) & i_in_valid;
  assign w_clear     = (r_state == S_IDLE) & i_start;
  assign w_last_beat = ((r_beat_cnt + c_K_ONE) == r_k_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_out_row   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k_len     <= i_k_len;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_out_row   <= '0;
            r_state     <= (i_k_len != '0) ? S_LOAD : S_FLUSH;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + c_K_ONE;
            if (w_last_beat) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt + c_FLUSH_ONE;
          if (r_flush_cnt == c_FLUSH_LAST) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_out_ready) begin
            if (r_out_row == c_LAST_ROW) begin
              r_out_row <= '0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_out_row <= r_out_row + c_ROW_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_overflow <= 1'b0;
    else if (w_clear)  r_overflow <= 1'b0;
    else if (|w_sat)   r_overflow <= 1'b1;
  end

  // Row r of the activation vector is delayed r cycles, carrying its valid bit.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    if (r == 0) begin : g_direct
      assign w_a_in[0][0]  = i_a_vec[0 +: DATA_WIDTH];
      assign w_a_vld[0][0] = w_accept;
    end else begin : g_delay
      logic [DATA_WIDTH:0] r_d [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < r; d++) r_d[d] <= '0;
        end else begin
          r_d[0] <= {w_accept, i_a_vec[r*DATA_WIDTH +: DATA_WIDTH]};
          for (int d = 1; d < r; d++) r_d[d] <= r_d[d-1];
        end
      end
      assign {w_a_vld[r][0], w_a_in[r][0]} = r_d[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w_skew
    if (c == 0) begin : g_direct
      assign w_w_in[0][0]  = i_w_vec[0 +: WEIGHT_WIDTH];
      assign w_w_vld[0][0] = w_accept;
    end else begin : g_delay
      logic [WEIGHT_WIDTH:0] r_d [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < c; d++) r_d[d] <= '0;
        end else begin
          r_d[0] <= {w_accept, i_w_vec[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
          for (int d = 1; d < c; d++) r_d[d] <= r_d[d-1];
        end
      end
      assign {w_w_vld[0][c], w_w_in[0][c]} = r_d[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      logic [ACCUM_WIDTH-1:0]     r_acc;
      logic signed [c_PROD_W-1:0] w_prod;
      logic [ACCUM_WIDTH:0]       w_sum;
      logic                       w_fire;
      logic                       w_ovf;

      assign w_fire = w_a_vld[r][c] & w_w_vld[r][c];
      assign w_prod = $signed(w_a_in[r][c]) * $signed(w_w_in[r][c]);
      // One guard bit: a sign mismatch between the top two bits means overflow.
      assign w_sum  = {r_acc[ACCUM_WIDTH-1], r_acc}
                    + {{(ACCUM_WIDTH+1-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
      assign w_ovf  = w_sum[ACCUM_WIDTH] ^ w_sum[ACCUM_WIDTH-1];
      assign w_sat[r*COLS+c] = w_fire & w_ovf;
      assign w_acc[r][c]     = r_acc;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_acc <= '0;
        else if (w_clear) r_acc <= '0;
        else if (w_fire)  r_acc <= !w_ovf ? w_sum[ACCUM_WIDTH-1:0]
                                 : (w_sum[ACCUM_WIDTH] ? c_ACC_MIN : c_ACC_MAX);
      end

      if (c < COLS-1) begin : g_pass_a
        logic [DATA_WIDTH:0] r_a;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_a <= '0;
          else        r_a <= {w_a_vld[r][c], w_a_in[r][c]};
        end
        assign {w_a_vld[r][c+1], w_a_in[r][c+1]} = r_a;
      end

      if (r < ROWS-1) begin : g_pass_w
        logic [WEIGHT_WIDTH:0] r_w;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_w <= '0;
          else        r_w <= {w_w_vld[r][c], w_w_in[r][c]};
        end
        assign {w_w_vld[r+1][c], w_w_in[r+1][c]} = r_w;
      end
    end
  end

  always_comb begin
    o_out_data = '0;
    if (r_state == S_DRAIN) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r_out_row == c_ROW_W'(r)) begin
          for (int c = 0; c < COLS; c++)
            o_out_data[c*ACCUM_WIDTH +: ACCUM_WIDTH] = w_acc[r][c];
        end
      end
    end
  end

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_out_valid = (r_state == S_DRAIN);
  assign o_out_row   = r_out_row;
  assign o_out_last  = (r_state == S_DRAIN) && (r_out_row == c_LAST_ROW);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_systolic_gemm_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for systolic_gemm_engine: a behavioural GEMM model queues
// expected rows at tile start; the drain loop pops and compares them.
module tb_systolic_gemm_engine;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int WW   = 8;
  localparam int AW   = 24;
  localparam int KW   = 8;
  localparam int RW   = $clog2(ROWS);
  localparam int KMAX = 8;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [KW-1:0]        i_k_len = '0;
  logic                 i_in_valid = 1'b0;
  logic                 o_in_ready;
  logic [ROWS*DW-1:0]   i_a_vec = '0;
  logic [COLS*WW-1:0]   i_w_vec = '0;
  logic                 o_out_valid;
  logic                 i_out_ready = 1'b0;
  logic [COLS*AW-1:0]   o_out_data;
  logic [RW-1:0]        o_out_row;
  logic                 o_out_last;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_overflow;

  systolic_gemm_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .ACCUM_WIDTH(AW), .K_WIDTH(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_a_vec(i_a_vec),
    .i_w_vec(i_w_vec), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_row(o_out_row), .o_out_last(o_out_last),
    .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int A [ROWS][KMAX];
  int W [KMAX][COLS];
  logic [COLS*AW-1:0] exp_q [$];
  logic exp_ovf;

  task automatic build_expected(input int k);
    exp_ovf = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      logic [COLS*AW-1:0] row;
      row = '0;
      for (int c = 0; c < COLS; c++) begin
        longint acc;
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + longint'(A[r][kk]) * longint'(W[kk][c]);
          if (acc > MAXV) begin acc = MAXV; exp_ovf = 1'b1; end
          if (acc < MINV) begin acc = MINV; exp_ovf = 1'b1; end
        end
        row[c*AW +: AW] = acc[AW-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic set_identity();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) A[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) W[k][c] = 4*k + c + 1;
  endtask

  task automatic set_random();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) A[r][k] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) W[k][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic start_tile(input int k);
    @(negedge clk);
    i_start = 1'b1;
    i_k_len = KW'(k);
    build_expected(k);
  endtask

  // mode 0: in_valid held high; mode 1: pattern 1,0,0,... plus stray start pulses
  task automatic feed(input int k, input int mode);
    int beat = 0;
    int cyc  = 0;
    bit v;
    while (beat < k && cyc < 200) begin
      @(negedge clk);
      cyc++;
      i_start = (mode == 1);
      i_k_len = KW'(1);
      v = (mode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
      i_in_valid = v;
      for (int r = 0; r < ROWS; r++)
        i_a_vec[r*DW +: DW] = v ? DW'(A[r][beat]) : DW'($urandom);
      for (int c = 0; c < COLS; c++)
        i_w_vec[c*WW +: WW] = v ? WW'(W[beat][c]) : WW'($urandom);
      if (v && o_in_ready) beat++;
    end
    checks++;
    if (beat < k) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d beats, required %0d", beat, k);
    end
  endtask

  task automatic drain(input int stall_row, input bit hold_valid);
    int row = 0, cyc = 0, stall = 0, wait_cyc = 0, saw_ready = 0, early_done = 0;
    bit started = 1'b0;
    logic [COLS*AW-1:0] held, exp_row;
    held = '0;
    while (row < ROWS && cyc < 300) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      i_in_valid = hold_valid;
      if (hold_valid) begin
        i_a_vec = {ROWS{DW'($urandom)}};
        i_w_vec = {COLS{WW'($urandom)}};
      end
      if (o_done) early_done++;
      if (!o_out_valid) begin
        i_out_ready = 1'b0;
        if (o_in_ready) saw_ready++;
        if (!started) wait_cyc++;
      end else begin
        if (!started) begin
          started = 1'b1;
          checks++;
          if (wait_cyc != ROWS + COLS) begin
            errors++;
            $display("FAIL flush_len: got %0d cycles, required %0d", wait_cyc, ROWS + COLS);
          end
        end
        if (row == stall_row && stall < 5) begin
          if (stall > 0) begin
            checks++;
            if (o_out_data !== held || o_out_row !== RW'(row)) begin
              errors++;
              $display("FAIL hold_stable: row %0d data %h, required %h row %0d",
                       o_out_row, o_out_data, held, row);
            end
          end
          held = o_out_data;
          stall++;
          i_out_ready = 1'b0;
        end else begin
          if (exp_q.size() > 0) exp_row = exp_q.pop_front();
          else exp_row = 'x;
          checks++;
          if (o_out_row !== RW'(row) || o_out_last !== (row == ROWS-1)) begin
            errors++;
            $display("FAIL row_index: row %0d last %b, required row %0d last %b",
                     o_out_row, o_out_last, row, (row == ROWS-1));
          end
          checks++;
          if (o_out_data !== exp_row) begin
            errors++;
            $display("FAIL row_data[%0d]: got %h, required %h", row, o_out_data, exp_row);
          end
          i_out_ready = 1'b1;
          row++;
        end
      end
    end
    checks++;
    if (row < ROWS) begin
      errors++;
      $display("FAIL drain_timeout: got %0d rows, required %0d", row, ROWS);
    end
    @(negedge clk);
    i_out_ready = 1'b0;
    i_in_valid  = 1'b0;
    checks++;
    if (o_done !== 1'b1 || early_done != 0) begin
      errors++;
      $display("FAIL done_pulse: done %b early %0d, required 1 and 0", o_done, early_done);
    end
    checks++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_return: busy %b out_valid %b, required 0 0", o_busy, o_out_valid);
    end
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow: got %b, required %b", o_overflow, exp_ovf);
    end
    checks++;
    if (saw_ready != 0) begin
      errors++;
      $display("FAIL in_ready_outside_load: seen %0d cycles, required 0", saw_ready);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got %b, required 0", o_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_overflow} !== 6'b0 ||
        o_out_row !== '0 || o_out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags %b row %0d data %h, required all zero",
               {o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_overflow},
               o_out_row, o_out_data);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_a_vec = {ROWS{DW'($urandom)}};
    end
    checks++;
    if ({o_in_ready, o_out_valid, o_busy, o_done, o_overflow} !== 5'b0 || o_out_data !== '0) begin
      errors++;
      $display("FAIL post_reset_quiet: flags %b data %h, required zero",
               {o_in_ready, o_out_valid, o_busy, o_done, o_overflow}, o_out_data);
    end
    i_in_valid = 1'b0;
  endtask

  task automatic test_identity();
    set_identity();
    start_tile(4);
    feed(4, 0);
    drain(-1, 1'b0);
  endtask

  task automatic test_bubbles();
    set_identity();
    start_tile(4);
    feed(4, 1);
    drain(-1, 1'b0);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) A[r][k] = 32767;
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) W[k][c] = 127;
    start_tile(3);
    feed(3, 0);
    drain(-1, 1'b0);
  endtask

  task automatic test_backpressure();
    set_random();
    start_tile(6);
    feed(6, 0);
    drain(1, 1'b0);
  endtask

  task automatic test_k_zero();
    start_tile(0);
    drain(-1, 1'b1);
  endtask

  task automatic test_reset_mid_tile();
    set_identity();
    start_tile(4);
    feed(2, 0);
    @(negedge clk);
    i_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_overflow} !== 6'b0 ||
        o_out_row !== '0 || o_out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: flags %b row %0d data %h, required all zero",
               {o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_overflow},
               o_out_row, o_out_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    test_identity();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      set_random();
      start_tile(KMAX);
      feed(KMAX, 0);
      drain(t, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bubbles();
    test_saturation();
    test_backpressure();
    test_k_zero();
    test_reset_mid_tile();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
